edge_lane_counter: RTL

Per-frame lane-occupancy counter sitting directly downstream of the image filter chain. It consumes the binary edge stream (the filter chain's ProcessOut) together with the video timing strobes and tracks the pixel position. For each of LANES vertical lanes inside a configurable horizontal band, it counts edge pixels. At every frame boundary it publishes the per-lane counts and hit flags to the note-detection / actuator logic.

---
 rtl/edge_lane_counter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/edge_lane_counter.sv
// edge_lane_counter
// Counts edge pixels in LANES vertical windows inside a horizontal line band and publishes
// the per-lane counts and hit flags once per frame. The first, partial frame after reset is
// discarded.
//
// Ports
//   CLK           pixel clock, rising edge
//   RST           synchronous active-high reset
//   VSync         vertical sync; a rising edge marks the frame boundary
//   VDE           video data enable; high during active pixels
//   EdgeIn        binary edge pixel, valid while VDE=1
//   LaneX         left column of lane i in [i*X_W +: X_W]
//   LaneWidth     common lane width in pixels
//   YTop/YBottom  inclusive band of lines that are counted
//   HitThreshold  minimum count for a lane hit
//   LaneCount     last completed frame's count, lane i in [i*CNT_W +: CNT_W]
//   LaneHit       bit i set when LaneCount_i >= HitThreshold of that frame
//   FrameValid    one-cycle pulse when new results are published
//   FrameCount    frames published since reset, wraps
module edge_lane_counter #(
    parameter int unsigned LANES = 5,
    parameter int unsigned X_W   = 11,
    parameter int unsigned Y_W   = 11,
    parameter int unsigned CNT_W = 12
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   VSync,
    input  logic                   VDE,
    input  logic                   EdgeIn,
    input  logic [LANES*X_W-1:0]   LaneX,
    input  logic [X_W-1:0]         LaneWidth,
    input  logic [Y_W-1:0]         YTop,
    input  logic [Y_W-1:0]         YBottom,
    input  logic [CNT_W-1:0]       HitThreshold,
    output logic [LANES*CNT_W-1:0] LaneCount,
    output logic [LANES-1:0]       LaneHit,
    output logic                   FrameValid,
    output logic [15:0]            FrameCount
);

    typedef enum logic {StWaitSync, StCount} state_e;

    localparam logic [X_W-1:0]   XOne   = 1;
    localparam logic [Y_W-1:0]   YOne   = 1;
    localparam logic [CNT_W-1:0] CntOne = 1;
    localparam logic [15:0]      FcOne  = 1;

    state_e           r_state;
    state_e           w_state_next;
    logic             r_vs_q;
    logic             r_vde_q;
    logic [X_W-1:0]   r_x;
    logic [Y_W-1:0]   r_y;

    // Configuration shadow, held constant for a whole frame
    logic [X_W-1:0]   r_lane_x [LANES];
    logic [X_W-1:0]   r_width;
    logic [Y_W-1:0]   r_ytop;
    logic [Y_W-1:0]   r_ybot;
    logic [CNT_W-1:0] r_thr;

    logic [CNT_W-1:0] r_acc        [LANES];
    logic [CNT_W-1:0] r_lane_count [LANES];
    logic [LANES-1:0] r_lane_hit;
    logic             r_frame_valid;
    logic [15:0]      r_frame_count;

    logic             w_vs_edge;
    logic             w_pix;
    logic [LANES-1:0] w_lane_pix;
    logic [LANES-1:0] w_hit_next;

    assign w_vs_edge = VSync & ~r_vs_q;

    // A pixel coinciding with the frame edge belongs to neither frame
    assign w_pix = VDE & EdgeIn & ~w_vs_edge & (r_state == StCount)
                 & (r_y >= r_ytop) & (r_y <= r_ybot);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [X_W:0] w_left;
        logic [X_W:0] w_right;
        // One extra bit so a window reaching past the last column does not wrap
        assign w_left        = {1'b0, r_lane_x[g]};
        assign w_right       = w_left + {1'b0, r_width};
        assign w_lane_pix[g] = w_pix & ({1'b0, r_x} >= w_left) & ({1'b0, r_x} < w_right);
        assign w_hit_next[g] = (r_acc[g] >= r_thr);
        assign LaneCount[g*CNT_W +: CNT_W] = r_lane_count[g];
    end

    assign LaneHit    = r_lane_hit;
    assign FrameValid = r_frame_valid;
    assign FrameCount = r_frame_count;

    always_comb begin
        w_state_next = r_state;
        if (r_state == StWaitSync && w_vs_edge) begin
            w_state_next = StCount;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state       <= StWaitSync;
            r_vs_q        <= 1'b0;
            r_vde_q       <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_width       <= '0;
            r_ytop        <= '0;
            r_ybot        <= '0;
            r_thr         <= '0;
            r_lane_hit    <= '0;
            r_frame_valid <= 1'b0;
            r_frame_count <= '0;
            for (int i = 0; i < LANES; i++) begin
                r_lane_x[i]     <= '0;
                r_acc[i]        <= '0;
                r_lane_count[i] <= '0;
            end
        end else begin
            r_state       <= w_state_next;
            r_vs_q        <= VSync;
            r_vde_q       <= VDE;
            r_frame_valid <= 1'b0;
            if (w_vs_edge) begin
                r_x     <= '0;
                r_y     <= '0;
                r_width <= LaneWidth;
                r_ytop  <= YTop;
                r_ybot  <= YBottom;
                r_thr   <= HitThreshold;
                for (int i = 0; i < LANES; i++) begin
                    r_lane_x[i] <= LaneX[i*X_W +: X_W];
                    r_acc[i]    <= '0;
                end
                // The first edge after reset only arms counting
                if (r_state == StCount) begin
                    for (int i = 0; i < LANES; i++) begin
                        r_lane_count[i] <= r_acc[i];
                    end
                    r_lane_hit    <= w_hit_next;
                    r_frame_valid <= 1'b1;
                    r_frame_count <= r_frame_count + FcOne;
                end
            end else begin
                if (VDE) begin
                    if (r_x != '1) r_x <= r_x + XOne;
                end else if (r_vde_q) begin
                    r_x <= '0;
                    if (r_y != '1) r_y <= r_y + YOne;
                end
                for (int i = 0; i < LANES; i++) begin
                    if (w_lane_pix[i] && (r_acc[i] != '1)) r_acc[i] <= r_acc[i] + CntOne;
                end
            end
        end
    end

endmodule
